// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the EN/RW/MFC handshake.
// Holds a word-addressed synchronous RAM. Each request is latched on
// acceptance and completed after LATENCY cycles by raising MFC. MFC and
// addr_err then stay high until the processor drops EN.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EN,
    input  logic        RW,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        MFC,
    output logic        addr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   dout_q, dout_d;
    logic          mfc_q, mfc_d;
    logic          err_q, err_d;

    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic [15:0]   rd_data_s;
    logic          mem_we_s;

    logic [15:0]   mem_q [DEPTH];

    // Decode the latched address: range check against DEPTH and RAM index.
    always_comb begin
        in_range_s = ({1'b0, addr_q} < 17'(DEPTH));
        idx_s      = addr_q[AW-1:0];
    end

    // RAM read port; out-of-range addresses read as zero.
    always_comb begin
        if (in_range_s) begin
            rd_data_s = mem_q[idx_s];
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // Handshake FSM: accept, count down the wait, complete, await EN low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        mfc_d    = mfc_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    rw_d    = RW;
                    addr_d  = address;
                    wdata_d = data_in;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!EN) begin
                    // Processor withdrew the request: cancel, nothing committed.
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    mfc_d   = 1'b1;
                    if (!in_range_s) begin
                        err_d = 1'b1;
                        if (rw_q) begin
                            dout_d = 16'h0000;
                        end else begin
                            dout_d = dout_q;
                        end
                    end else if (rw_q) begin
                        dout_d = rd_data_s;
                    end else begin
                        mem_we_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mfc_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Control and output registers; async reset returns to an idle handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            dout_q  <= 16'h0000;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_s] <= wdata_q;
        end
    end

    // Drive outputs straight from registers.
    always_comb begin
        data_out = dout_q;
        MFC      = mfc_q;
        addr_err = err_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances with LATENCY 2, 1, 5, 3.
module tb_mem_responder;

    typedef struct {
        logic [15:0] dout;
        logic        err;
    } exp_t;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 5;
            default: return 3;
        endcase
    endfunction

    logic        clk;
    logic        reset;
    logic        en_s   [4];
    logic        rw_s   [4];
    logic [15:0] addr_s [4];
    logic [15:0] din_s  [4];
    logic [15:0] dout_s [4];
    logic        mfc_s  [4];
    logic        err_s  [4];

    logic [15:0] mem_m  [4][256];
    logic [15:0] dout_m [4];
    exp_t        exp_q  [$];
    exp_t        last_e;

    int n_vec;
    int n_err;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            mem_responder #(.DEPTH(256), .LATENCY(lat_of(g))) u_dut (
                .clk      (clk),
                .reset    (reset),
                .EN       (en_s[g]),
                .RW       (rw_s[g]),
                .address  (addr_s[g]),
                .data_in  (din_s[g]),
                .data_out (dout_s[g]),
                .MFC      (mfc_s[g]),
                .addr_err (err_s[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic scramble(input int d);
        addr_s[d] = 16'($urandom);
        din_s[d]  = 16'($urandom);
        rw_s[d]   = 1'($urandom_range(0, 1));
    endtask

    // Drive a request; returns just after the acceptance edge.
    task automatic start_acc(input int d, input logic rw, input logic [15:0] a,
                             input logic [15:0] wd, input bit commit);
        exp_t e;
        @(posedge clk); #1;
        en_s[d]   = 1'b1;
        rw_s[d]   = rw;
        addr_s[d] = a;
        din_s[d]  = wd;
        if (commit) begin
            e.err = (a >= 16'd256);
            if (rw) begin
                e.dout = e.err ? 16'h0000 : mem_m[d][a[7:0]];
            end else begin
                e.dout = dout_m[d];
                if (!e.err) mem_m[d][a[7:0]] = wd;
            end
            dout_m[d] = e.dout;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        chk_val("mfc_pre", 32'(mfc_s[d]), 32'd0);
    endtask

    // Wait (bounded) for MFC, check latency and pop the scoreboard.
    task automatic wait_mfc(input int d, input bit scr);
        int n;
        n = 0;
        while (n < 20 && mfc_s[d] !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (scr) scramble(d);
        end
        chk_val("mfc_rise", 32'(mfc_s[d]), 32'd1);
        chk_val("latency", 32'(n), 32'(lat_of(d)));
        chk_val("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            last_e = exp_q.pop_front();
            chk_val("data_out", 32'(dout_s[d]), 32'(last_e.dout));
            chk_val("addr_err", 32'(err_s[d]), 32'(last_e.err));
        end
    endtask

    // Hold EN for a while, then drop it and check MFC falls on the next edge.
    task automatic finish_acc(input int d, input int hold, input bit scr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (scr) scramble(d);
            chk_val("mfc_hold", 32'(mfc_s[d]), 32'd1);
            chk_val("dout_hold", 32'(dout_s[d]), 32'(last_e.dout));
            chk_val("err_hold", 32'(err_s[d]), 32'(last_e.err));
        end
        en_s[d] = 1'b0;
        @(posedge clk); #1;
        chk_val("mfc_fall", 32'(mfc_s[d]), 32'd0);
        chk_val("err_fall", 32'(err_s[d]), 32'd0);
        chk_val("dout_keep", 32'(dout_s[d]), 32'(last_e.dout));
    endtask

    task automatic acc(input int d, input logic rw, input logic [15:0] a,
                       input logic [15:0] wd, input int hold, input bit scr);
        start_acc(d, rw, a, wd, 1'b1);
        wait_mfc(d, scr);
        finish_acc(d, hold, scr);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_val("rst_mfc", 32'(mfc_s[i]), 32'd0);
            chk_val("rst_dout", 32'(dout_s[i]), 32'd0);
            chk_val("rst_err", 32'(err_s[i]), 32'd0);
            en_s[i]   = 1'b0;
            dout_m[i] = 16'h0000;
        end
        #2 reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en_s[i]   = 1'b0;
            rw_s[i]   = 1'b0;
            addr_s[i] = 16'h0000;
            din_s[i]  = 16'h0000;
            dout_m[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_val("reset_mfc", 32'(mfc_s[i]), 32'd0);
            chk_val("reset_err", 32'(err_s[i]), 32'd0);
            chk_val("reset_dout", 32'(dout_s[i]), 32'd0);
        end
        reset = 1'b1;

        // Write then read back.
        acc(0, 1'b0, 16'h0010, 16'hBEEF, 0, 1'b0);
        acc(0, 1'b1, 16'h0010, 16'h0000, 0, 1'b0);

        // Latency sweep on the LATENCY=1 and LATENCY=5 instances.
        acc(1, 1'b0, 16'h0003, 16'h0333, 0, 1'b0);
        acc(1, 1'b1, 16'h0003, 16'h0000, 1, 1'b0);
        acc(2, 1'b0, 16'h0003, 16'h0555, 0, 1'b0);
        acc(2, 1'b1, 16'h0003, 16'h0000, 1, 1'b0);

        // Out-of-range accesses.
        acc(0, 1'b0, 16'h0000, 16'hC0DE, 0, 1'b0);
        acc(0, 1'b0, 16'h0100, 16'h1234, 0, 1'b0);
        acc(0, 1'b1, 16'h0000, 16'h0000, 0, 1'b0);
        acc(0, 1'b1, 16'h0100, 16'h0000, 0, 1'b0);
        acc(0, 1'b1, 16'hFFFF, 16'h0000, 0, 1'b0);

        // Abort during WAIT on the LATENCY=3 instance.
        acc(3, 1'b0, 16'h0005, 16'h0F0F, 0, 1'b0);
        start_acc(3, 1'b0, 16'h0005, 16'hAAAA, 1'b0);
        en_s[3] = 1'b0;
        for (int i = 0; i < lat_of(3) + 3; i++) begin
            @(posedge clk); #1;
            chk_val("abort_mfc", 32'(mfc_s[3]), 32'd0);
        end
        acc(3, 1'b1, 16'h0005, 16'h0000, 0, 1'b0);

        // Inputs wander after acceptance; MFC held with EN for 10 cycles.
        acc(0, 1'b0, 16'h0020, 16'h4242, 10, 1'b1);
        acc(0, 1'b1, 16'h0020, 16'h0000, 10, 1'b1);
        acc(0, 1'b1, 16'h0010, 16'h0000, 0, 1'b0);

        // Reset during WAIT of a write to address 7.
        acc(0, 1'b0, 16'h0007, 16'h0707, 0, 1'b0);
        acc(0, 1'b1, 16'h0020, 16'h0000, 0, 1'b0);
        start_acc(0, 1'b0, 16'h0007, 16'hDEAD, 1'b0);
        pulse_reset();
        acc(0, 1'b1, 16'h0007, 16'h0000, 0, 1'b0);

        // Reset during DONE after a committed write to address 8.
        start_acc(0, 1'b0, 16'h0008, 16'h5555, 1'b1);
        wait_mfc(0, 1'b0);
        pulse_reset();
        acc(0, 1'b1, 16'h0008, 16'h0000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the processor's EN/RW/MFC memory handshake. It holds a word-addressed synchronous RAM and accepts one read or write per handshake. After a programmable wait it completes the access and raises MFC (memory function complete). It sits between the processor top's address/data_out/RW/EN outputs and its data_in/MFC inputs.

Parameters:
DEPTH, 256, number of 16-bit words implemented (1..65536); valid addresses are 0..DEPTH-1.
LATENCY, 2, cycles from EN acceptance to MFC assertion (1..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
EN  input  1  access request from the processor; held high until MFC is seen.
RW  input  1  access type: 1 = read, 0 = write; sampled with EN.
address  input  16  word address; sampled with EN.
data_in  input  16  write data from the processor's data_out; sampled with EN.
data_out  output  16  read data to the processor's data_in.
MFC  output  1  access complete; held high until EN drops.
addr_err  output  1  high together with MFC when the access address is >= DEPTH.

Behaviour:
- Reset (reset=0, async): state=IDLE, MFC=0, addr_err=0, data_out=16'h0000, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on a rising edge with EN=1:
  - latch RW, address and data_in into internal registers;
  - load counter with LATENCY-1;
  - go to WAIT.
  - Later changes on the inputs are ignored for this access.
- WAIT:
  - If EN=0 at an edge: abort, return to IDLE, no RAM write, outputs unchanged.
  - Else if counter=0: perform the access and go to DONE.
  - Else decrement the counter.
- Access performed on the WAIT->DONE edge:
  - Read, in range: data_out <= RAM[addr].
  - Write, in range: RAM[addr] <= latched data; data_out unchanged.
  - Out of range (addr >= DEPTH): no RAM write; a read loads data_out <= 16'h0000; addr_err <= 1.
- Timing: EN sampled at edge k gives MFC=1 from edge k+LATENCY. LATENCY=1 gives MFC one cycle after acceptance.
- DONE:
  - MFC=1; addr_err holds; data_out is held stable.
  - When EN=0 at an edge: MFC <= 0, addr_err <= 0, go to IDLE. data_out keeps its last value.
- Back-to-back requests: EN must be seen low for at least one edge in DONE. A new request is accepted no earlier than the edge after MFC falls, i.e. minimum one IDLE cycle between accesses.
- RW changes while in WAIT/DONE are ignored.
- Reset asserted in WAIT: access cancelled, no write committed. Reset asserted in DONE: a committed write remains in RAM; MFC drops immediately.
- Only one access is outstanding at a time; no pipelining.

Test Plan:
1. Write then read: EN=1, RW=0, address=16'h0010, data_in=16'hBEEF. MFC rises 2 cycles later; drop EN; MFC falls next edge. Then EN=1, RW=1, address=16'h0010 -> data_out=16'hBEEF when MFC=1, addr_err=0.
2. Latency sweep: rebuild with LATENCY=1 and LATENCY=5. Read of address 3 -> MFC at exactly edge k+1 and k+5 after EN acceptance.
3. Out of range, DEPTH=256:
   - Write 16'h1234 to 16'h0100 -> MFC=1 and addr_err=1.
   - Then read 16'h0000 -> prior contents unchanged.
   - Read of 16'h0100 -> data_out=16'h0000, addr_err=1.
4. Abort: EN=1 write 16'hAAAA to address 5, drop EN during WAIT (LATENCY=3) -> MFC never rises; a subsequent read of address 5 returns the old value.
5. Input instability: after acceptance, change address, data_in and RW each cycle -> the access uses the values latched at acceptance. MFC stays high while EN=1 for 10 cycles; data_out is stable throughout.
6. Async reset:
   - Pulse reset low mid-WAIT on a write to address 7 -> MFC=0 immediately, data_out=0, address 7 unchanged.
   - Pulse reset low in DONE after a write of 16'h5555 to address 8 -> a later read returns 16'h5555.
